// File: rtl/uart_loopback_ctrl.sv
// UART loopback controller: echoes received bytes through a small FIFO or emits an
// incrementing byte stream, with a retriggerable display hold. Optional: UART_LOOPBACK_STATS_EN.
module uart_loopback_ctrl #(
    parameter int UART_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int SHOW_CYCLES   = 2**26,
    parameter int TX_GAP_CYCLES = 2**26,
    parameter int GEN_INIT      = 10
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          mode,
    input  logic                          clr,
    input  logic                          rx_new_byte,
    input  logic [UART_WIDTH-1:0]         rx_byte,
    input  logic                          tx_ready,
    output logic                          tx_start,
    output logic [UART_WIDTH-1:0]         tx_byte,
    output logic [UART_WIDTH-1:0]         disp_byte,
    output logic                          disp_show,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [1:0]                    state
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
    localparam int GAP_W  = (TX_GAP_CYCLES > 1) ? $clog2(TX_GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_tx_start;
    logic [UART_WIDTH-1:0]   r_tx_byte;
    logic [UART_WIDTH-1:0]   r_gen;
    logic                    r_src_echo;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic                    r_run;

    logic [UART_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic [UART_WIDTH-1:0]   r_disp_byte;
    logic [SHOW_W-1:0]       r_show_cnt;
    logic                    r_overflow;

    logic                    w_push_req;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_avail;

    // The head entry leaves the FIFO at the end of START, so a push arriving in
    // that same cycle can take its slot even when the FIFO is full.
    assign w_push_req = rx_new_byte & ~mode;
    assign w_pop      = (r_state == ST_START) & r_src_echo;
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push;
    assign w_avail    = mode | (r_count != '0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
            r_gen      <= UART_WIDTH'(GEN_INIT);
            r_src_echo <= 1'b0;
            r_gap_cnt  <= '0;
            r_run      <= 1'b0;
        end else begin
            // r_run holds off transmission for the first clock after reset release.
            r_run      <= 1'b1;
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_run && tx_ready && w_avail) begin
                        r_state    <= ST_START;
                        r_tx_start <= 1'b1;
                        r_src_echo <= ~mode;
                        if (mode) begin
                            r_tx_byte <= r_gen;
                            r_gen     <= r_gen + 1'b1;
                        end else begin
                            r_tx_byte <= r_mem[r_rd_ptr];
                        end
                    end
                end
                ST_START: begin
                    r_state   <= ST_GAP;
                    r_gap_cnt <= '0;
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(TX_GAP_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_disp_byte <= '0;
            r_show_cnt  <= '0;
        end else if (rx_new_byte) begin
            r_disp_byte <= rx_byte;
            r_show_cnt  <= SHOW_W'(SHOW_CYCLES);
        end else if (r_show_cnt != '0) begin
            r_show_cnt <= r_show_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef UART_LOOPBACK_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = '0;
`endif

    assign tx_start   = r_tx_start;
    assign tx_byte    = r_tx_byte;
    assign disp_byte  = r_disp_byte;
    assign disp_show  = (r_show_cnt != '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign state      = r_state;

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Directed bench for uart_loopback_ctrl: echo, overflow, simultaneous push/pop,
// generator with wrap, reset mid-GAP, display retrigger and clear priority.
module tb_uart_loopback_ctrl;

    logic        clk;
    logic        rstN;
    logic        mode;
    logic        clr;
    logic        rx_new_byte;
    logic [7:0]  rx_byte;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic [7:0]  disp_byte;
    logic        disp_show;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int n;

`ifdef UART_LOOPBACK_STATS_EN
    localparam logic [15:0] EXP_DROP_2 = 16'd2;
    localparam logic [15:0] EXP_DROP_1 = 16'd1;
`else
    localparam logic [15:0] EXP_DROP_2 = 16'd0;
    localparam logic [15:0] EXP_DROP_1 = 16'd0;
`endif

    uart_loopback_ctrl #(
        .UART_WIDTH   (8),
        .FIFO_DEPTH   (4),
        .SHOW_CYCLES  (6),
        .TX_GAP_CYCLES(3),
        .GEN_INIT     (10)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .mode       (mode),
        .clr        (clr),
        .rx_new_byte(rx_new_byte),
        .rx_byte    (rx_byte),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .disp_byte  (disp_byte),
        .disp_show  (disp_show),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next tx_start pulse; returns the number of clocks waited.
    task automatic wait_tx(input logic [7:0] exp, output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            waited++;
            if (tx_start) seen = 1'b1;
        end
        check("tx_start_seen", 32'(seen), 32'd1);
        check("tx_byte", 32'(tx_byte), 32'(exp));
    endtask

    task automatic push(input logic [7:0] b);
        rx_new_byte = 1'b1;
        rx_byte     = b;
        tick();
        rx_new_byte = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; mode = 1'b0; clr = 1'b0;
        rx_new_byte = 1'b0; rx_byte = 8'h00; tx_ready = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_state", 32'(state), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_disp_byte", 32'(disp_byte), 32'd0);
        check("rst_disp_show", 32'(disp_show), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rstN = 1'b1;
        tx_ready = 1'b1;
        tick(); tick();

        // Echo: A5 in, tx_start two clocks later
        push(8'hA5);
        check("echo_c1_tx_start", 32'(tx_start), 32'd0);
        check("echo_c1_fifo_count", 32'(fifo_count), 32'd1);
        check("echo_disp_byte", 32'(disp_byte), 32'hA5);
        check("echo_disp_show", 32'(disp_show), 32'd1);
        tick();
        check("echo_c2_tx_start", 32'(tx_start), 32'd1);
        check("echo_c2_tx_byte", 32'(tx_byte), 32'hA5);
        check("echo_c2_state", 32'(state), 32'd1);
        tick();
        check("echo_c3_tx_start", 32'(tx_start), 32'd0);
        check("echo_c3_state", 32'(state), 32'd2);
        check("echo_c3_fifo_count", 32'(fifo_count), 32'd0);
        tick(); tick(); tick();
        check("echo_show_last", 32'(disp_show), 32'd1);
        check("echo_idle_again", 32'(state), 32'd0);
        tick();
        check("echo_show_off", 32'(disp_show), 32'd0);
        check("echo_tx_byte_hold", 32'(tx_byte), 32'hA5);

        // Overflow: six bytes into a four-entry FIFO with the transmitter busy
        tx_ready = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            push(8'(b));
        end
        check("ovf_fifo_count", 32'(fifo_count), 32'd4);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_drop_count", 32'(drop_count), 32'(EXP_DROP_2));
        check("ovf_disp_byte", 32'(disp_byte), 32'd6);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_drop_count", 32'(drop_count), 32'd0);
        check("clr_fifo_kept", 32'(fifo_count), 32'd4);

        // Full FIFO: push during the START cycle that pops the head
        tx_ready = 1'b1;
        tick();
        check("pp_tx_start", 32'(tx_start), 32'd1);
        check("pp_tx_byte", 32'(tx_byte), 32'd1);
        check("pp_fifo_count_start", 32'(fifo_count), 32'd4);
        push(8'd7);
        check("pp_fifo_count", 32'(fifo_count), 32'd4);
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_state", 32'(state), 32'd2);
        wait_tx(8'd2, n);
        wait_tx(8'd3, n);
        check("echo_period", 32'(n), 32'd5);
        wait_tx(8'd4, n);
        wait_tx(8'd7, n);

        // Generator: mode changes mid-START and takes effect at the next IDLE
        mode = 1'b1;
        wait_tx(8'd10, n);
        check("gen_first_delay", 32'(n), 32'd5);
        check("gen_fifo_untouched", 32'(fifo_count), 32'd0);
        wait_tx(8'd11, n);
        check("gen_period_11", 32'(n), 32'd5);
        wait_tx(8'd12, n);
        check("gen_period_12", 32'(n), 32'd5);
        for (int v = 13; v <= 255; v++) begin
            wait_tx(8'(v), n);
        end
        wait_tx(8'd0, n);
        check("gen_wrap_period", 32'(n), 32'd5);
        wait_tx(8'd1, n);

        // Reset while in GAP
        tick();
        check("pre_rst_state_gap", 32'(state), 32'd2);
        rstN = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_tx_byte", 32'(tx_byte), 32'd0);
        check("arst_disp_byte", 32'(disp_byte), 32'd0);
        check("arst_fifo_count", 32'(fifo_count), 32'd0);
        tick();
        rstN = 1'b1;
        tick();
        check("rel_c1_tx_start", 32'(tx_start), 32'd0);
        check("rel_c1_state", 32'(state), 32'd0);
        tick();
        check("rel_c2_tx_start", 32'(tx_start), 32'd1);
        check("rel_gen_restart", 32'(tx_byte), 32'd10);
        tx_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check("rel_back_idle", 32'(state), 32'd0);

        // Display retrigger one clock before expiry (generator mode, no FIFO push)
        push(8'h33);
        check("rt_show_first", 32'(disp_show), 32'd1);
        tick(); tick(); tick(); tick();
        check("rt_show_before", 32'(disp_show), 32'd1);
        push(8'h44);
        check("rt_disp_byte", 32'(disp_byte), 32'h44);
        tick(); tick(); tick(); tick(); tick();
        check("rt_show_extended", 32'(disp_show), 32'd1);
        tick();
        check("rt_show_off", 32'(disp_show), 32'd0);
        check("rt_no_push_in_gen", 32'(fifo_count), 32'd0);

        // clr beats a drop in the same cycle
        mode = 1'b0;
        push(8'h81); push(8'h82); push(8'h83); push(8'h84);
        clr = 1'b1;
        push(8'h85);
        clr = 1'b0;
        check("clrwin_overflow", 32'(overflow), 32'd0);
        check("clrwin_drop_count", 32'(drop_count), 32'd0);
        check("clrwin_fifo_count", 32'(fifo_count), 32'd4);
        push(8'h86);
        check("drop1_overflow", 32'(overflow), 32'd1);
        check("drop1_drop_count", 32'(drop_count), 32'(EXP_DROP_1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr2_overflow", 32'(overflow), 32'd0);
        check("clr2_drop_count", 32'(drop_count), 32'd0);

        tx_ready = 1'b1;
        wait_tx(8'h81, n);
        wait_tx(8'h82, n);
        wait_tx(8'h83, n);
        wait_tx(8'h84, n);
        tick(); tick(); tick(); tick(); tick();
        check("final_fifo_empty", 32'(fifo_count), 32'd0);
        check("final_state_idle", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
